seq_alu_acc: RTL and testbench
==============================

// Module: seq_alu_acc
// PURPOSE
// - Registered, parametrised successor of the board-level 4-bit ALU: W-bit A/B operands, 2W-bit result register.
// - Adds a start/busy/done handshake, a multi-cycle shift-add multiply, and an accumulate op fed back from the result register.
// - Sits between the operand/function switch decode and the LEDR/HEX display logic. Display decoding stays outside this block.
// PARAMETERS
// - W  4  operand width in bits (W >= 2). Result width is 2W.
// PORTS
// - clk     in   1   system clock; all state updates on rising edge
// - reset   in   1   asynchronous, active-high; clears all state immediately
// - start   in   1   request; sampled only when busy=0
// - op      in   3   function select, sampled with start
// - a       in   W   operand A, sampled with start
// - b       in   W   operand B, sampled with start
// - result  out  2W  registered result; holds its value between operations
// - busy    out  1   high while a multiply is in progress
// - done    out  1   one-cycle pulse: result updated this cycle
// - zero    out  1   registered; 1 when result==0
// BEHAVIOUR
// - Reset: result=0, busy=0, done=0, zero=1, FSM=IDLE, iteration counter=0.
// - Reset asserted mid-multiply: aborts; no done pulse; result=0.
// - FSM states: IDLE, MUL.
//   - IDLE with start=1 and op!=110: result written on that edge; done=1 for exactly the next cycle; stays IDLE. Latency 1.
//   - IDLE with start=1 and op=110: latch a, b; clear product; busy=1 from the next cycle; go to MUL.
//   - MUL: W iterations, one per cycle. Each iteration: if multiplier LSB=1, add shifted multiplicand to product; shift.
//   - After the Wth iteration: result=product, done=1 for one cycle, busy=0, back to IDLE.
//   - Multiply latency: start edge to done = W+1 cycles.
// - start while busy=1: ignored. Operands are not re-sampled.
// - Back-to-back single-cycle ops: start held high in IDLE launches a new op every cycle; done stays high each cycle.
// - Ops. All results zero-extended to 2W; upper bits 0 unless stated.
//   - 000: a+1. Carry goes to bit W.
//   - 001: a+b via ripple-carry full-adder chain. Carry goes to bit W.
//   - 010: a+b via built-in '+'. Must equal op 001 for all inputs.
//   - 011: {a|b, a^b} in the low 2W bits.
//   - 100: 1 if (|a)|(|b), else 0.
//   - 101: {a, b}.
//   - 110: a*b, unsigned, full 2W-bit product (multi-cycle, see above).
//   - 111: accumulate: result + a, a zero-extended, wraps mod 2^(2W).
// - zero updates on the same edge as result.
// CONFIGURATION
// - Macro SEQ_ALU_ACC_SAT_EN.
//   - Defined: op 111 saturates at 2^(2W)-1 instead of wrapping.
//   - Undefined: op 111 wraps modulo 2^(2W).
//   - No other op is affected either way.
// TESTING (W=4 unless noted)
// - Reset while result=0x3C: result=0x00, zero=1, done=0, busy=0 immediately, before any clock edge.
// - op=001, a=0xF, b=0x1, start 1 cycle -> next cycle result=0x10, done=1; following cycle done=0.
//   - Repeat with op=010 -> identical result.
// - op=110, a=0xF, b=0xF -> busy=1 for 4 cycles, done exactly 5 cycles after the start edge, result=0xE1.
//   - start pulsed during busy is ignored.
// - op=111, a=0xF, repeated 18 times from result=0 -> result=0x0E (wrap).
//   - With SEQ_ALU_ACC_SAT_EN -> result=0xFF, holds at 0xFF.
// - op=110, a=0x7, b=0x3; assert reset after 2 MUL cycles -> result=0x00, busy=0, no done.
//   - A new op=101, a=0xA, b=0x5 afterwards -> result=0xA5.
// - op=011, a=0xC, b=0xA -> result=0xE6. op=100, a=0, b=0 -> result=0x00, zero=1.

Source files
------------

// File: rtl/seq_alu_acc.sv
// seq_alu_acc: registered W-bit ALU with a 2W-bit result register, a
// start/busy/done handshake, a multi-cycle shift-add multiply (op 110) and
// an accumulate op (op 111) fed back from the result register.
//
// Ports:
//   clk     - system clock, rising edge
//   reset   - asynchronous, active-high; clears all state
//   start   - request, sampled only while busy=0
//   op      - function select, sampled with start
//   a, b    - W-bit operands, sampled with start
//   result  - 2W-bit registered result, holds between operations
//   busy    - high while a multiply is in progress
//   done    - one-cycle pulse, result updated this cycle
//   zero    - registered, 1 when result==0
//
// Configuration macro SEQ_ALU_ACC_SAT_EN: when defined, op 111 saturates at
// 2^(2W)-1; when undefined it wraps modulo 2^(2W).

module seq_alu_acc #(
  parameter int unsigned W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  output logic [2*W-1:0]    result,
  output logic              busy,
  output logic              done,
  output logic              zero
);

  localparam int unsigned RW = 2 * W;
  localparam int unsigned SW = W + 1;
  localparam int unsigned AW = RW + 1;
  localparam int unsigned CW = $clog2(W + 1);

  localparam logic [2:0] OP_INC    = 3'b000;
  localparam logic [2:0] OP_ADD_RC = 3'b001;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_LOGIC  = 3'b011;
  localparam logic [2:0] OP_ANY    = 3'b100;
  localparam logic [2:0] OP_CAT    = 3'b101;
  localparam logic [2:0] OP_MUL    = 3'b110;
  localparam logic [2:0] OP_ACC    = 3'b111;

  typedef enum logic [0:0] {IDLE, MUL} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   mcand_q;
  logic [W-1:0]    mplier_q;
  logic [RW-1:0]   product_q;
  logic [CW-1:0]   cnt_q;

  logic            launch_single_c;
  logic            launch_mul_c;
  logic            mul_last_c;
  logic [RW-1:0]   alu_c;
  logic [RW-1:0]   prod_step_c;
  logic [SW-1:0]   ripple_c;
  logic            carry_c;
  logic [AW-1:0]   acc_sum_c;
  logic [RW-1:0]   acc_c;

  // Next-state and launch decode
  always_comb begin
    state_d         = state_q;
    launch_single_c = 1'b0;
    launch_mul_c    = 1'b0;
    mul_last_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            launch_mul_c = 1'b1;
            state_d      = MUL;
          end else begin
            launch_single_c = 1'b1;
          end
        end
      end
      MUL: begin
        if (cnt_q == CW'(W - 1)) begin
          mul_last_c = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle function unit
  always_comb begin
    ripple_c = '0;
    carry_c  = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      ripple_c[i] = a[i] ^ b[i] ^ carry_c;
      carry_c     = (a[i] & b[i]) | (carry_c & (a[i] ^ b[i]));
    end
    ripple_c[W] = carry_c;

    acc_sum_c = {1'b0, result} + AW'(a);
`ifdef SEQ_ALU_ACC_SAT_EN
    acc_c = acc_sum_c[RW] ? {RW{1'b1}} : acc_sum_c[RW-1:0];
`else
    acc_c = acc_sum_c[RW-1:0];
`endif

    alu_c = '0;
    case (op)
      OP_INC:    alu_c = RW'(a) + RW'(1);
      OP_ADD_RC: alu_c = RW'(ripple_c);
      OP_ADD:    alu_c = RW'(SW'(a) + SW'(b));
      OP_LOGIC:  alu_c = {a | b, a ^ b};
      OP_ANY:    alu_c = RW'((|a) | (|b));
      OP_CAT:    alu_c = {a, b};
      OP_ACC:    alu_c = acc_c;
      default:   alu_c = '0;
    endcase
  end

  // One shift-add iteration; used directly for the final write so the last
  // iteration and the result update share an edge.
  always_comb begin
    prod_step_c = product_q + (mplier_q[0] ? mcand_q : '0);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      cnt_q     <= '0;
      result    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      zero      <= 1'b1;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == MUL);
      done    <= 1'b0;

      if (launch_single_c) begin
        result <= alu_c;
        zero   <= (alu_c == '0);
        done   <= 1'b1;
      end

      if (launch_mul_c) begin
        mcand_q   <= RW'(a);
        mplier_q  <= b;
        product_q <= '0;
        cnt_q     <= '0;
      end

      if (state_q == MUL) begin
        product_q <= prod_step_c;
        mcand_q   <= mcand_q << 1;
        mplier_q  <= mplier_q >> 1;
        cnt_q     <= mul_last_c ? '0 : cnt_q + CW'(1);
      end

      if (mul_last_c) begin
        result <= prod_step_c;
        zero   <= (prod_step_c == '0);
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu_acc.sv
// tb_seq_alu_acc: self-checking bench for seq_alu_acc (W=4).
// Expected results are queued when a request is driven and compared when
// done pulses; table-driven single-cycle and multiply vectors plus
// hand-written reset/accumulate sequences.

module tb_seq_alu_acc;

  localparam int unsigned W  = 4;
  localparam int unsigned RW = 2 * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [RW-1:0] result;
  logic          busy;
  logic          done;
  logic          zero;

  always #5 clk = ~clk;

  seq_alu_acc #(.W(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result),
    .busy   (busy),
    .done   (done),
    .zero   (zero)
  );

  typedef struct {
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [RW-1:0] exp;
  } vec_t;

  vec_t          vecs[12];
  vec_t          mvecs[5];
  logic [RW-1:0] sb[$];
  logic [RW-1:0] model;
  int            checks   = 0;
  int            failures = 0;
  int            n;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; sample at the falling edge and retire one expected
  // result from the scoreboard whenever done is seen.
  task automatic tick();
    logic [RW-1:0] e;
    @(posedge clk);
    @(negedge clk);
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", RW'(done), RW'(0));
      end else begin
        e = sb.pop_front();
        chk("result", result, e);
        chk("zero", RW'(zero), RW'(e == '0));
      end
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
  endtask

  function automatic logic [RW-1:0] acc_model(input logic [RW-1:0] cur, input logic [W-1:0] av);
    logic [RW:0] s;
    s = {1'b0, cur} + {{(RW + 1 - W){1'b0}}, av};
`ifdef SEQ_ALU_ACC_SAT_EN
    return s[RW] ? {RW{1'b1}} : s[RW-1:0];
`else
    return s[RW-1:0];
`endif
  endfunction

  initial begin
    vecs[0]  = '{3'b001, 4'hF, 4'h1, 8'h10};
    vecs[1]  = '{3'b010, 4'hF, 4'h1, 8'h10};
    vecs[2]  = '{3'b011, 4'hC, 4'hA, 8'hE6};
    vecs[3]  = '{3'b100, 4'h0, 4'h0, 8'h00};
    vecs[4]  = '{3'b100, 4'h0, 4'h1, 8'h01};
    vecs[5]  = '{3'b101, 4'hA, 4'h5, 8'hA5};
    vecs[6]  = '{3'b000, 4'hF, 4'h3, 8'h10};
    vecs[7]  = '{3'b000, 4'h3, 4'h0, 8'h04};
    vecs[8]  = '{3'b001, 4'h7, 4'h8, 8'h0F};
    vecs[9]  = '{3'b010, 4'h9, 4'h9, 8'h12};
    vecs[10] = '{3'b001, 4'h0, 4'h0, 8'h00};
    vecs[11] = '{3'b011, 4'h5, 4'h5, 8'h50};

    mvecs[0] = '{3'b110, 4'hF, 4'hF, 8'hE1};
    mvecs[1] = '{3'b110, 4'h7, 4'h3, 8'h15};
    mvecs[2] = '{3'b110, 4'hA, 4'hB, 8'h6E};
    mvecs[3] = '{3'b110, 4'h0, 4'hF, 8'h00};
    mvecs[4] = '{3'b110, 4'hF, 4'h1, 8'h0F};

    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    #1;
    chk("reset_result", result, 8'h00);
    chk("reset_zero", RW'(zero), RW'(1));
    chk("reset_busy", RW'(busy), RW'(0));
    chk("reset_done", RW'(done), RW'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Isolated add: done for one cycle only
    drive(3'b001, 4'hF, 4'h1);
    sb.push_back(8'h10);
    tick();
    chk("add_done", RW'(done), RW'(1));
    start = 1'b0;
    tick();
    chk("add_done_low", RW'(done), RW'(0));

    // Back-to-back single-cycle ops with start held high
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      sb.push_back(vecs[i].exp);
      tick();
      chk("b2b_done", RW'(done), RW'(1));
    end
    start = 1'b0;
    tick();
    chk("b2b_done_low", RW'(done), RW'(0));

    // Multiplies, with an ignored start pulse (different op/operands) while busy
    foreach (mvecs[i]) begin
      drive(mvecs[i].op, mvecs[i].a, mvecs[i].b);
      sb.push_back(mvecs[i].exp);
      tick();
      n = 1;
      chk("mul_busy", RW'(busy), RW'(1));
      drive(3'b101, 4'hF, 4'hF);
      while (done !== 1'b1 && n < 12) begin
        tick();
        n++;
        start = 1'b0;
        if (done !== 1'b1) chk("mul_busy", RW'(busy), RW'(1));
      end
      start = 1'b0;
      chk("mul_latency", RW'(n), RW'(5));
      chk("mul_busy_end", RW'(busy), RW'(0));
      tick();
      chk("mul_done_low", RW'(done), RW'(0));
    end

    // Accumulate 18x 0xF from zero
    drive(3'b100, 4'h0, 4'h0);
    sb.push_back(8'h00);
    tick();
    model = 8'h00;
    for (int i = 0; i < 18; i++) begin
      drive(3'b111, 4'hF, 4'h0);
      model = acc_model(model, 4'hF);
      sb.push_back(model);
      tick();
    end
    start = 1'b0;
    tick();
`ifdef SEQ_ALU_ACC_SAT_EN
    chk("acc_final", result, 8'hFF);
`else
    chk("acc_final", result, 8'h0E);
`endif

    // Asynchronous reset with result=0x3C, checked before any clock edge
    drive(3'b101, 4'h3, 4'hC);
    sb.push_back(8'h3C);
    tick();
    start = 1'b0;
    reset = 1'b1;
    #1;
    chk("areset_result", result, 8'h00);
    chk("areset_zero", RW'(zero), RW'(1));
    chk("areset_done", RW'(done), RW'(0));
    chk("areset_busy", RW'(busy), RW'(0));
    @(negedge clk);
    reset = 1'b0;

    // Reset two cycles into a multiply: aborted, no done
    drive(3'b110, 4'h7, 4'h3);
    sb.push_back(8'h15);
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    sb.delete();
    chk("abort_result", result, 8'h00);
    chk("abort_busy", RW'(busy), RW'(0));
    chk("abort_done", RW'(done), RW'(0));
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_done", RW'(done), RW'(0));
    end
    drive(3'b101, 4'hA, 4'h5);
    sb.push_back(8'hA5);
    tick();
    start = 1'b0;
    chk("after_abort_result", result, 8'hA5);
    tick();

    chk("scoreboard_empty", RW'(sb.size()), RW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
